piso_serializer: RTL

Parametrised parallel-in/serial-out serializer and the successor to the fixed 4-bit shift registers. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock-enable cycle, LSB-first or MSB-first. Each bit carries a valid qualifier and the final bit of a word carries a last flag. Consecutive words are shifted back-to-back with no idle bit between them. It sits between a word-producing datapath and a serial line driver or downstream bit sink.

---
 rtl/shift_pkg.sv | 25 ++
 rtl/bit_down_counter.sv | 40 ++++
 rtl/piso_serializer.sv | 114 +++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the PISO serializer.
//   state_e     : serializer FSM states
//   bit_order_e : which end of the word leaves the serializer first
//   cnt_width() : bit-counter width for a given word width, never below 1
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef enum logic {
        ORDER_MSB_FIRST = 1'b0,
        ORDER_LSB_FIRST = 1'b1
    } bit_order_e;

    // Counter holds values 0..w-1, so $clog2(w) bits suffice.
    // The floor of 1 keeps degenerate widths from producing a zero-width vector.
    function automatic int cnt_width(input int w);
        int b;
        b = $clog2(w);
        return (b < 1) ? 1 : b;
    endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter with enable and zero flag.
//   clk, reset : clock, synchronous active-high reset (clears to 0)
//   load       : load load_val (takes priority over en)
//   load_val   : value to load
//   en         : decrement by one; saturates at 0 (never wraps)
//   zero       : count is 0
module bit_down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer.
// Accepts WIDTH-bit words over valid/ready and shifts them out one bit per
// clken-high cycle, LSB- or MSB-first. Back-to-back words leave no idle bit.
//   clk, reset : clock, synchronous active-high reset
//   clken      : bit-advance enable
//   in_valid   : word offered on in_data
//   in_ready   : word can be accepted this cycle
//   in_data    : parallel word
//   ser_out    : current serial bit (IDLE_LEVEL when idle)
//   ser_valid  : ser_out carries a data bit
//   last       : ser_out is the final bit of the word
//   busy       : a word is being shifted
module piso_serializer
    import shift_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   LSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clken,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             last,
    output logic             busy
);

    localparam int               CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    LAST_IDX = CW'(WIDTH - 1);
    localparam bit_order_e       ORDER    = LSB_FIRST ? ORDER_LSB_FIRST : ORDER_MSB_FIRST;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shift_next;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_zero;
    logic             accept;

    bit_down_counter #(
        .WIDTH (CW)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LAST_IDX),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // Ready when idle, or when the final bit of the current word is being
    // consumed this cycle so the next word follows without a gap.
    // Held low during reset so nothing is accepted then.
    assign in_ready = !reset &&
                      ((state_q == IDLE) || ((state_q == SHIFT) && clken && cnt_zero));
    assign accept   = in_valid && in_ready;

    // Move the register toward its output end, zero-filling behind.
    assign shift_next = (ORDER == ORDER_LSB_FIRST) ? {1'b0, shift_q[WIDTH-1:1]}
                                                   : {shift_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d  = in_data;
                    cnt_load = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (clken) begin
                    if (cnt_zero) begin
                        if (accept) begin
                            shift_d  = in_data;
                            cnt_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shift_d = shift_next;
                        cnt_en  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign ser_valid = busy;
    assign last      = busy && cnt_zero;
    assign ser_out   = !busy ? IDLE_LEVEL
                     : (ORDER == ORDER_LSB_FIRST) ? shift_q[0] : shift_q[WIDTH-1];

endmodule
